stage_ex: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, between the ID/EX register and the memory stage.
- Selects operands, computes the ALU result, branch target, zero flag and destination register, and registers them into the EX/MEM pipeline register.
- Contains an iterative multiplier for the MUL op. It stalls upstream until the product is ready.

---
 rtl/stage_ex_if.sv | 36 +++
 rtl/stage_ex.sv | 130 +++++++++++++
 tb/tb_stage_ex.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_ex_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, plus operand forwarding taps.
// master drives the stage inputs (upstream/bench); slave is the stage itself.
interface stage_ex_if;
  logic        reg_write_in, mem_to_reg_in, mem_write_in, branch_in;
  logic        alu_src_in, reg_dst_in;
  logic [3:0]  alu_ctrl_in;
  logic [31:0] rs_data_in, rt_data_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic [9:0]  pc_in;
  logic [4:0]  fw_mem_wr, fw_wb_wr;
  logic        fw_mem_reg_write, fw_wb_reg_write;
  logic [31:0] fw_mem_data, fw_wb_data;

  logic        reg_write_out, mem_to_reg_out, mem_write_out, branch_out;
  logic        zero_out;
  logic [31:0] alu_result_out, write_data_out;
  logic [4:0]  wr_out;
  logic [9:0]  branch_target_out, pc_out;
  logic        stall_out;

  modport master (
    output reg_write_in, mem_to_reg_in, mem_write_in, branch_in, alu_src_in, reg_dst_in,
           alu_ctrl_in, rs_data_in, rt_data_in, imm_in, rs_in, rt_in, rd_in, pc_in,
           fw_mem_wr, fw_wb_wr, fw_mem_reg_write, fw_wb_reg_write, fw_mem_data, fw_wb_data,
    input  reg_write_out, mem_to_reg_out, mem_write_out, branch_out, zero_out,
           alu_result_out, write_data_out, wr_out, branch_target_out, pc_out, stall_out
  );

  modport slave (
    input  reg_write_in, mem_to_reg_in, mem_write_in, branch_in, alu_src_in, reg_dst_in,
           alu_ctrl_in, rs_data_in, rt_data_in, imm_in, rs_in, rt_in, rd_in, pc_in,
           fw_mem_wr, fw_wb_wr, fw_mem_reg_write, fw_wb_reg_write, fw_mem_data, fw_wb_data,
    output reg_write_out, mem_to_reg_out, mem_write_out, branch_out, zero_out,
           alu_result_out, write_data_out, wr_out, branch_target_out, pc_out, stall_out
  );
endinterface

// File: rtl/stage_ex.sv
// MIPS execute stage: ALU + iterative MUL into EX/MEM on the falling edge; STAGE_EX_FORWARD_EN adds MEM/WB forwarding.
// Latency 1 enabled edge (MUL: 34 with N=32); stall_out holds ID/EX while a MUL is issuing or stepping.
module stage_ex #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clk_enable,
  stage_ex_if.slave ex
);
  localparam int STEPS = 32 / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state, state_nxt;
  logic [CW-1:0] step_cnt;
  logic [31:0] mul_a, mul_b, mul_acc, partial;
  logic [31:0] rs_val, rt_val, op_b, alu_res, result;
  logic        issue, bubble;

`ifdef STAGE_EX_FORWARD_EN
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    if (ex.fw_mem_reg_write && (r != 5'd0) && (ex.fw_mem_wr == r)) return ex.fw_mem_data;
    if (ex.fw_wb_reg_write && (r != 5'd0) && (ex.fw_wb_wr == r))   return ex.fw_wb_data;
    return rf;
  endfunction
  assign rs_val = fwd(ex.rs_in, ex.rs_data_in);
  assign rt_val = fwd(ex.rt_in, ex.rt_data_in);
`else
  assign rs_val = ex.rs_data_in;
  assign rt_val = ex.rt_data_in;
`endif

  assign op_b = ex.alu_src_in ? ex.imm_in : rt_val;

  always_comb begin
    alu_res = '0;
    case (ex.alu_ctrl_in)
      4'd0:    alu_res = rs_val & op_b;
      4'd1:    alu_res = rs_val | op_b;
      4'd2:    alu_res = rs_val + op_b;
      4'd6:    alu_res = rs_val - op_b;
      4'd7:    alu_res = {31'd0, $signed(rs_val) < $signed(op_b)};
      4'd12:   alu_res = ~(rs_val | op_b);
      4'd3:    alu_res = rt_val << ex.imm_in[10:6];
      default: alu_res = '0;
    endcase
  end

  // Low 32 bits of a signed product equal those of the unsigned one, so plain shift-add suffices.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mul_b[i]) partial = partial + (mul_a << i);
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = (state == IDLE) && (ex.alu_ctrl_in == 4'd8);
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (step_cnt == CW'(STEPS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bubble       = issue || (state == BUSY);
  assign result       = (state == DONE) ? mul_acc : alu_res;
  assign ex.stall_out = !reset && bubble;

  always_ff @(negedge clk) begin
    if (reset) begin
      state                <= IDLE;
      step_cnt             <= '0;
      mul_a                <= '0;
      mul_b                <= '0;
      mul_acc              <= '0;
      ex.reg_write_out     <= 1'b0;
      ex.mem_to_reg_out    <= 1'b0;
      ex.mem_write_out     <= 1'b0;
      ex.branch_out        <= 1'b0;
      ex.zero_out          <= 1'b0;
      ex.alu_result_out    <= '0;
      ex.write_data_out    <= '0;
      ex.wr_out            <= '0;
      ex.branch_target_out <= '0;
      ex.pc_out            <= '0;
    end else if (clk_enable) begin
      state <= state_nxt;
      if (issue) begin
        mul_a    <= rs_val;
        mul_b    <= op_b;
        mul_acc  <= '0;
        step_cnt <= '0;
      end else if (state == BUSY) begin
        mul_acc  <= mul_acc + partial;
        mul_a    <= mul_a << BITS_PER_CYCLE;
        mul_b    <= mul_b >> BITS_PER_CYCLE;
        step_cnt <= step_cnt + 1'b1;
      end

      if (bubble) begin
        ex.reg_write_out     <= 1'b0;
        ex.mem_to_reg_out    <= 1'b0;
        ex.mem_write_out     <= 1'b0;
        ex.branch_out        <= 1'b0;
        ex.zero_out          <= 1'b0;
        ex.alu_result_out    <= '0;
        ex.write_data_out    <= '0;
        ex.wr_out            <= '0;
        ex.branch_target_out <= '0;
        ex.pc_out            <= '0;
      end else begin
        ex.reg_write_out     <= ex.reg_write_in;
        ex.mem_to_reg_out    <= ex.mem_to_reg_in;
        ex.mem_write_out     <= ex.mem_write_in;
        ex.branch_out        <= ex.branch_in;
        ex.zero_out          <= (result == 32'd0);
        ex.alu_result_out    <= result;
        ex.write_data_out    <= rt_val;
        ex.wr_out            <= ex.reg_dst_in ? ex.rd_in : ex.rt_in;
        ex.branch_target_out <= ex.pc_in + ex.imm_in[9:0];
        ex.pc_out            <= ex.pc_in;
      end
    end
  end
endmodule

// File: tb/tb_stage_ex.sv
// Randomized self-checking bench for stage_ex against a behavioural model of the execute stage.
module tb_stage_ex;
  localparam int BPC       = 1;
  localparam int MUL_STALL = 32 / BPC + 1;

  logic clk = 1'b0;
  logic reset, clk_enable;
  always #5 clk = ~clk;

  stage_ex_if ex();
  stage_ex #(.BITS_PER_CYCLE(BPC)) dut (.clk(clk), .reset(reset), .clk_enable(clk_enable), .ex(ex));

  typedef struct packed {
    logic        rw, m2r, mw, br, zero;
    logic [31:0] res, wdata;
    logic [4:0]  wr;
    logic [9:0]  bt, pc;
  } out_t;

  int n_pass = 0;
  int n_total = 0;

  function automatic out_t observed();
    out_t o;
    o.rw = ex.reg_write_out; o.m2r = ex.mem_to_reg_out; o.mw = ex.mem_write_out;
    o.br = ex.branch_out; o.zero = ex.zero_out; o.res = ex.alu_result_out;
    o.wdata = ex.write_data_out; o.wr = ex.wr_out; o.bt = ex.branch_target_out; o.pc = ex.pc_out;
    return o;
  endfunction

  function automatic logic [31:0] opval(input logic [4:0] r, input logic [31:0] rf);
`ifdef STAGE_EX_FORWARD_EN
    if (ex.fw_mem_reg_write && r != 0 && ex.fw_mem_wr == r) return ex.fw_mem_data;
    if (ex.fw_wb_reg_write && r != 0 && ex.fw_wb_wr == r) return ex.fw_wb_data;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] alu_model();
    logic [31:0] a, rt, b;
    longint p;
    a  = opval(ex.rs_in, ex.rs_data_in);
    rt = opval(ex.rt_in, ex.rt_data_in);
    b  = ex.alu_src_in ? ex.imm_in : rt;
    case (ex.alu_ctrl_in)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      4'd3:  return rt << ex.imm_in[10:6];
      4'd8: begin
        p = longint'(int'(a)) * longint'(int'(b));
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic out_t expect_now(input logic [31:0] result);
    out_t e;
    e.rw = ex.reg_write_in; e.m2r = ex.mem_to_reg_in; e.mw = ex.mem_write_in; e.br = ex.branch_in;
    e.zero = (result == 0); e.res = result;
    e.wdata = opval(ex.rt_in, ex.rt_data_in);
    e.wr = ex.reg_dst_in ? ex.rd_in : ex.rt_in;
    e.bt = ex.pc_in + ex.imm_in[9:0];
    e.pc = ex.pc_in;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rsd, rtd, imm,
                       input logic src, input logic rand_fw);
    ex.alu_ctrl_in = op; ex.rs_data_in = rsd; ex.rt_data_in = rtd; ex.imm_in = imm;
    ex.alu_src_in = src;
    ex.reg_dst_in = 1'($urandom_range(0, 1)); ex.reg_write_in = 1'($urandom_range(0, 1));
    ex.mem_to_reg_in = 1'($urandom_range(0, 1)); ex.mem_write_in = 1'($urandom_range(0, 1));
    ex.branch_in = 1'($urandom_range(0, 1));
    ex.rs_in = 5'($urandom_range(0, 3)); ex.rt_in = 5'($urandom_range(0, 3));
    ex.rd_in = 5'($urandom); ex.pc_in = 10'($urandom);
    ex.fw_mem_wr = 5'($urandom_range(0, 3)); ex.fw_wb_wr = 5'($urandom_range(0, 3));
    ex.fw_mem_reg_write = rand_fw & 1'($urandom_range(0, 1));
    ex.fw_wb_reg_write  = rand_fw & 1'($urandom_range(0, 1));
    ex.fw_mem_data = $urandom; ex.fw_wb_data = $urandom;
  endtask

  task automatic test_reset();
    out_t e;
    reset = 1'b1; clk_enable = 1'b1;
    drive(4'd2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (observed() !== out_t'(0)) $display("FAIL reset_outputs edge %0d: got %h want 0", i, observed());
      else n_pass++;
      n_total++;
      if (ex.stall_out !== 1'b0) $display("FAIL reset_stall edge %0d: got %b want 0", i, ex.stall_out);
      else n_pass++;
    end
    ex.alu_ctrl_in = 4'd8;
    #1;
    n_total++;
    if (ex.stall_out !== 1'b0) $display("FAIL reset_stall_mul: got %b want 0", ex.stall_out);
    else n_pass++;
    ex.alu_ctrl_in = 4'd2;
    reset = 1'b0;
    e = expect_now(32'd12);
    tick();
    n_total++;
    if (ex.alu_result_out !== 32'd12 || ex.zero_out !== 1'b0)
      $display("FAIL first_add: got %h zero %b want 0000000c zero 0", ex.alu_result_out, ex.zero_out);
    else n_pass++;
    n_total++;
    if (observed() !== e) $display("FAIL first_add_fields: got %h want %h", observed(), e);
    else n_pass++;
  endtask

  task automatic test_sub_slt();
    drive(4'd6, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    tick();
    n_total++;
    if (ex.alu_result_out !== 32'd0 || ex.zero_out !== 1'b1)
      $display("FAIL sub_zero: got %h zero %b want 0 zero 1", ex.alu_result_out, ex.zero_out);
    else n_pass++;
    drive(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    tick();
    n_total++;
    if (ex.alu_result_out !== 32'd1 || ex.zero_out !== 1'b0)
      $display("FAIL slt_signed: got %h zero %b want 1 zero 0", ex.alu_result_out, ex.zero_out);
    else n_pass++;
  endtask

  task automatic test_alu_random();
    logic [3:0] ops [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd5, 4'd15};
    out_t e;
    for (int i = 0; i < 60; i++) begin
      drive(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      if (i % 10 == 0) ex.rs_data_in = ex.rt_data_in;
      e = expect_now(alu_model());
      tick();
      n_total++;
      if (observed() !== e)
        $display("FAIL alu_random %0d op %0d: got %h want %h", i, ex.alu_ctrl_in, observed(), e);
      else n_pass++;
    end
    drive(4'd2, 32'd1, 32'd2, 32'd1, 1'b1, 1'b0);
    ex.pc_in = 10'd1023;
    tick();
    n_total++;
    if (ex.branch_target_out !== 10'd0) $display("FAIL branch_wrap: got %0d want 0", ex.branch_target_out);
    else n_pass++;
  endtask

  task automatic do_mul(input logic [31:0] a, b, input int freeze_at, freeze_len,
                        input logic rand_fw, output logic [31:0] got);
    logic [31:0] prod;
    out_t e;
    int edges, bad, frz_bad;
    drive(4'd8, a, b, $urandom, 1'b0, rand_fw);
    prod = alu_model();
    #1;
    n_total++;
    if (ex.stall_out !== 1'b1) $display("FAIL mul_issue_stall: got %b want 1", ex.stall_out);
    else n_pass++;
    edges = 0; bad = 0; frz_bad = 0;
    while (ex.stall_out === 1'b1 && edges < 200) begin
      if (edges == freeze_at) begin
        clk_enable = 1'b0;
        for (int k = 0; k < freeze_len; k++) begin
          tick(); edges++;
          if (ex.stall_out !== 1'b1 || observed() !== out_t'(0)) frz_bad++;
        end
        clk_enable = 1'b1;
      end
      tick(); edges++;
      if (observed() !== out_t'(0)) bad++;
    end
    n_total++;
    if (edges != MUL_STALL + freeze_len)
      $display("FAIL mul_stall_edges: got %0d want %0d", edges, MUL_STALL + freeze_len);
    else n_pass++;
    n_total++;
    if (bad != 0 || frz_bad != 0)
      $display("FAIL mul_bubbles: got %0d bad bubbles %0d bad frozen edges want 0", bad, frz_bad);
    else n_pass++;
    e = expect_now(prod);
    tick();
    got = ex.alu_result_out;
    n_total++;
    if (observed() !== e) $display("FAIL mul_result: got %h want %h", observed(), e);
    else n_pass++;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    do_mul(32'hFFFF_FFFD, 32'd7, -1, 0, 1'b0, r);
    n_total++;
    if (r !== 32'hFFFF_FFEB) $display("FAIL mul_fixed: got %h want ffffffeb", r);
    else n_pass++;
    ex.alu_ctrl_in = 4'd0;
    for (int i = 0; i < 2; i++) begin
      do_mul($urandom, $urandom, -1, 0, 1'b1, r);
      ex.alu_ctrl_in = 4'd1;
    end
  endtask

  task automatic test_mul_reset();
    out_t e;
    drive(4'd8, 32'd123, 32'd456, 32'd0, 1'b0, 1'b0);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    n_total++;
    if (ex.stall_out !== 1'b0) $display("FAIL mul_abort_stall: got %b want 0", ex.stall_out);
    else n_pass++;
    tick();
    n_total++;
    if (observed() !== out_t'(0)) $display("FAIL mul_abort_outputs: got %h want 0", observed());
    else n_pass++;
    drive(4'd2, $urandom, $urandom, $urandom, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    n_total++;
    if (ex.stall_out !== 1'b0) $display("FAIL post_abort_stall: got %b want 0", ex.stall_out);
    else n_pass++;
    e = expect_now(alu_model());
    tick();
    n_total++;
    if (observed() !== e) $display("FAIL post_abort_add: got %h want %h", observed(), e);
    else n_pass++;
  endtask

  task automatic test_enable();
    out_t held, e;
    logic [31:0] r;
    drive(4'd1, $urandom, $urandom, $urandom, 1'b1, 1'b1);
    held = expect_now(alu_model());
    tick();
    drive(4'd2, $urandom, $urandom, $urandom, 1'b0, 1'b1);
    clk_enable = 1'b0;
    repeat (3) tick();
    n_total++;
    if (observed() !== held) $display("FAIL enable_hold: got %h want %h", observed(), held);
    else n_pass++;
    clk_enable = 1'b1;
    e = expect_now(alu_model());
    tick();
    n_total++;
    if (observed() !== e) $display("FAIL enable_resume: got %h want %h", observed(), e);
    else n_pass++;
    do_mul($urandom, $urandom, 10, 5, 1'b1, r);
    ex.alu_ctrl_in = 4'd0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    do_mul($urandom, $urandom, -1, 0, 1'b1, r);
    do_mul(32'h8000_0001, 32'hFFFF_FFFF, -1, 0, 1'b0, r);
    n_total++;
    if (r !== 32'h7FFF_FFFF) $display("FAIL b2b_second: got %h want 7fffffff", r);
    else n_pass++;
    ex.alu_ctrl_in = 4'd0;
  endtask

  task automatic test_forward();
    logic [31:0] want_hit, want_wb;
`ifdef STAGE_EX_FORWARD_EN
    want_hit = 32'h111; want_wb = 32'h122;
`else
    want_hit = 32'h105; want_wb = 32'h105;
`endif
    drive(4'd2, 32'h5, 32'h0, 32'h100, 1'b1, 1'b0);
    ex.rs_in = 5'd4; ex.fw_mem_wr = 5'd4; ex.fw_wb_wr = 5'd4;
    ex.fw_mem_reg_write = 1'b1; ex.fw_wb_reg_write = 1'b1;
    ex.fw_mem_data = 32'h11; ex.fw_wb_data = 32'h22;
    tick();
    n_total++;
    if (ex.alu_result_out !== want_hit) $display("FAIL fwd_mem_prio: got %h want %h", ex.alu_result_out, want_hit);
    else n_pass++;
    ex.fw_mem_reg_write = 1'b0;
    tick();
    n_total++;
    if (ex.alu_result_out !== want_wb) $display("FAIL fwd_wb: got %h want %h", ex.alu_result_out, want_wb);
    else n_pass++;
    ex.fw_mem_reg_write = 1'b1;
    ex.rs_in = 5'd0; ex.fw_mem_wr = 5'd0; ex.fw_wb_wr = 5'd0;
    tick();
    n_total++;
    if (ex.alu_result_out !== 32'h105) $display("FAIL fwd_r0: got %h want 00000105", ex.alu_result_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sub_slt();
    test_alu_random();
    test_mul();
    test_mul_reset();
    test_enable();
    test_back_to_back();
    test_forward();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
